ir_fetch: RTL

- Instruction fetch stage directly upstream of the decoder.
- Issues word reads from program memory at the fetch PC.
- Buffers the returned 32-bit instruction words, laid out as ir_t ({cond_e[31:28], instruction_e[27:20], params[19:0]}), in a small queue.
- Presents them to decode with a valid/ready handshake.
- Handles jump redirects, including discarding a read already in flight.

---
 rtl/ir_fetch.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/ir_fetch.sv
// rtl/ir_fetch.sv - instruction fetch stage with small instruction queue and jump redirect
module ir_fetch #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    QUEUE_DEPTH = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_data,
  input  logic                  mem_ack,
  input  logic                  jump,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  output logic [31:0]           ir,
  output logic [ADDR_WIDTH-1:0] ir_pc,
  output logic                  ir_valid,
  input  logic                  ir_ready
);

  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CW-1:0]         DEPTH = CW'(QUEUE_DEPTH);
  localparam logic [PW-1:0]         LAST  = PW'(QUEUE_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE   = ADDR_WIDTH'(1);

  // IDLE: no request; WAIT: request whose data is wanted; DROP: request whose data is thrown away
  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] fetch_pc, fetch_pc_n;
  logic [ADDR_WIDTH-1:0] mem_addr_n;
  logic                  push, flush, pop;

  logic [PW-1:0]         head, tail, head_pop, head_n, tail_n;
  logic [CW-1:0]         count, cnt_pop, cnt_push, count_n;
  logic [31:0]           ir_n;
  logic [ADDR_WIDTH-1:0] ir_pc_n;
  logic                  ir_valid_n;

  logic [31:0]           q_data [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] q_pc   [QUEUE_DEPTH];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // occupancy after this cycle's pop, and after a possible push on top of it
  always_comb begin
    pop      = ir_valid && ir_ready;
    cnt_pop  = count - CW'(pop);
    cnt_push = cnt_pop + CW'(1);
    head_pop = pop ? ptr_inc(head) : head;
  end

  // fetch FSM: next state, next request address, push/flush decisions
  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    mem_addr_n = mem_addr;
    push       = 1'b0;
    flush      = 1'b0;
    case (state)
      IDLE: begin
        if (jump) begin
          fetch_pc_n = jump_addr;
          mem_addr_n = jump_addr;
          flush      = 1'b1;
          state_n    = WAIT;
        end else if (count < DEPTH) begin
          mem_addr_n = fetch_pc;
          state_n    = WAIT;
        end
      end
      WAIT: begin
        if (jump) begin
          flush      = 1'b1;
          fetch_pc_n = jump_addr;
          if (mem_ack) begin
            mem_addr_n = jump_addr;
          end else begin
            state_n = DROP;
          end
        end else if (mem_ack) begin
          push       = 1'b1;
          fetch_pc_n = mem_addr + ONE;
          // only keep the request line busy while a free slot is guaranteed
          if (cnt_push < DEPTH) begin
            mem_addr_n = mem_addr + ONE;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DROP: begin
        if (jump) begin
          fetch_pc_n = jump_addr;
        end
        if (mem_ack) begin
          // a jump landing on the same cycle as the stale ack wins over the older target
          mem_addr_n = jump ? jump_addr : fetch_pc;
          state_n    = WAIT;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // queue pointers and the registered head-of-queue view presented to decode
  always_comb begin
    head_n     = head_pop;
    tail_n     = push ? ptr_inc(tail) : tail;
    count_n    = push ? cnt_push : cnt_pop;
    ir_n       = ir;
    ir_pc_n    = ir_pc;
    ir_valid_n = 1'b0;
    if (flush) begin
      head_n  = '0;
      tail_n  = '0;
      count_n = '0;
    end else begin
      ir_valid_n = (count_n != '0);
      if (push && cnt_pop == '0) begin
        ir_n    = mem_data;
        ir_pc_n = mem_addr;
      end else if (cnt_pop != '0) begin
        ir_n    = q_data[head_pop];
        ir_pc_n = q_pc[head_pop];
      end
    end
  end

  // queue storage written at the tail on every accepted read
  always_ff @(posedge clk) begin
    if (push) begin
      q_data[tail] <= mem_data;
      q_pc[tail]   <= mem_addr;
    end
  end

  // state, request and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      mem_addr <= '0;
      mem_rd   <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      mem_addr <= mem_addr_n;
      mem_rd   <= (state_n != IDLE);
      head     <= head_n;
      tail     <= tail_n;
      count    <= count_n;
      ir       <= ir_n;
      ir_pc    <= ir_pc_n;
      ir_valid <= ir_valid_n;
    end
  end

endmodule
